// File: rtl/io_port_pkg.sv
// Shared definitions for the I/O port bank: port-index sizing, empty/full flag
// polarity and flat-vector slice arithmetic.
package io_port_pkg;

    // A flag bit of 1 means the FIFO can be accessed (not empty / not full).
    localparam logic EF_READ_READY  = 1'b1;
    localparam logic EF_WRITE_READY = 1'b1;

    function automatic int unsigned idx_width(input int unsigned count);
        return (count > 1) ? unsigned'($clog2(count)) : 1;
    endfunction

    function automatic int unsigned slice_lsb(input int unsigned idx, input int unsigned width);
        return idx * width;
    endfunction

endpackage

// File: rtl/io_port_decoder.sv
// Maps an operand address onto a port index within a contiguous port window.
module io_port_decoder
    import io_port_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned BASE_ADDR  = 0,
    parameter int unsigned PORT_COUNT = 2,
    parameter int unsigned IDX_WIDTH  = idx_width(PORT_COUNT)
) (
    input  logic                  en,
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic                  hit,
    output logic [IDX_WIDTH-1:0]  idx
);

    localparam logic [ADDR_WIDTH-1:0] BASE  = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH:0]   COUNT = (ADDR_WIDTH + 1)'(PORT_COUNT);

    logic [ADDR_WIDTH-1:0] offset;

    always_comb begin
        offset = addr - BASE;
        hit    = en && (addr >= BASE) && ({1'b0, offset} < COUNT);
        idx    = IDX_WIDTH'(offset);
    end

endmodule

// File: rtl/io_port_bank.sv
// Memory-mapped FIFO port bank with atomic read/write access, per-thread
// retry counting and sticky timeout flags.
module io_port_bank
    import io_port_pkg::*;
#(
    parameter int unsigned WORD_WIDTH        = 36,
    parameter int unsigned ADDR_WIDTH        = 10,
    parameter int unsigned READ_PORT_COUNT   = 2,
    parameter int unsigned READ_BASE_ADDR    = 0,
    parameter int unsigned WRITE_PORT_COUNT  = 2,
    parameter int unsigned WRITE_BASE_ADDR   = 0,
    parameter int unsigned THREAD_COUNT      = 8,
    parameter int unsigned THREAD_ADDR_WIDTH = 3,
    parameter int unsigned RETRY_WIDTH       = 8,
    parameter int unsigned RETRY_LIMIT       = 255
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic                                   read_en,
    input  logic [ADDR_WIDTH-1:0]                  read_addr,
    input  logic                                   write_en,
    input  logic [ADDR_WIDTH-1:0]                  write_addr,
    input  logic [WORD_WIDTH-1:0]                  write_data,
    input  logic [READ_PORT_COUNT-1:0]             io_in_EF,
    input  logic [WORD_WIDTH*READ_PORT_COUNT-1:0]  io_in,
    input  logic [WRITE_PORT_COUNT-1:0]            io_out_EF,
    input  logic [THREAD_COUNT-1:0]                clear_timeout,
    output logic [READ_PORT_COUNT-1:0]             io_rden,
    output logic [WRITE_PORT_COUNT-1:0]            io_wren,
    output logic [WORD_WIDTH*WRITE_PORT_COUNT-1:0] io_out,
    output logic [WORD_WIDTH-1:0]                  read_data,
    output logic                                   IO_ready,
    output logic [THREAD_ADDR_WIDTH-1:0]           thread_id,
    output logic [THREAD_COUNT-1:0]                io_timeout
);

    localparam int unsigned RIDX_W = idx_width(READ_PORT_COUNT);
    localparam int unsigned WIDX_W = idx_width(WRITE_PORT_COUNT);
    localparam logic [RETRY_WIDTH-1:0]       RETRY_MAX   = '1;
    localparam logic [RETRY_WIDTH-1:0]       LIMIT       = RETRY_WIDTH'(RETRY_LIMIT);
    localparam logic [THREAD_ADDR_WIDTH-1:0] LAST_THREAD = THREAD_ADDR_WIDTH'(THREAD_COUNT - 1);

    logic              rd_hit, wr_hit;
    logic [RIDX_W-1:0] rd_idx;
    logic [WIDX_W-1:0] wr_idx;
    logic              rd_ok, wr_ok, access_ready;

    logic [THREAD_ADDR_WIDTH-1:0]           thread_q, thread_d;
    logic [RETRY_WIDTH-1:0]                 retry_q [THREAD_COUNT];
    logic [RETRY_WIDTH-1:0]                 retry_d [THREAD_COUNT];
    logic [THREAD_COUNT-1:0]                timeout_q, timeout_d;
    logic [READ_PORT_COUNT-1:0]             rden_q, rden_d;
    logic [WRITE_PORT_COUNT-1:0]            wren_q, wren_d;
    logic [WORD_WIDTH*WRITE_PORT_COUNT-1:0] out_q, out_d;
    logic [WORD_WIDTH-1:0]                  rdata_q, rdata_d;
    logic                                   ready_q, ready_d;

    io_port_decoder #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .BASE_ADDR  (READ_BASE_ADDR),
        .PORT_COUNT (READ_PORT_COUNT),
        .IDX_WIDTH  (RIDX_W)
    ) u_read_decoder (
        .en   (read_en),
        .addr (read_addr),
        .hit  (rd_hit),
        .idx  (rd_idx)
    );

    io_port_decoder #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .BASE_ADDR  (WRITE_BASE_ADDR),
        .PORT_COUNT (WRITE_PORT_COUNT),
        .IDX_WIDTH  (WIDX_W)
    ) u_write_decoder (
        .en   (write_en),
        .addr (write_addr),
        .hit  (wr_hit),
        .idx  (wr_idx)
    );

    always_comb begin
        rd_ok        = !rd_hit || (io_in_EF[rd_idx] == EF_READ_READY);
        wr_ok        = !wr_hit || (io_out_EF[wr_idx] == EF_WRITE_READY);
        access_ready = rd_ok && wr_ok;

        thread_d = (thread_q == LAST_THREAD) ? '0 : thread_q + THREAD_ADDR_WIDTH'(1);

        retry_d = retry_q;
        if (access_ready) begin
            retry_d[thread_q] = '0;
        end else if (retry_q[thread_q] != RETRY_MAX) begin
            retry_d[thread_q] = retry_q[thread_q] + RETRY_WIDTH'(1);
        end

        // Set is level-driven by the registered count, so it overrides a clear.
        for (int unsigned th = 0; th < THREAD_COUNT; th++) begin
            timeout_d[th] = (retry_q[th] >= LIMIT) || (timeout_q[th] && !clear_timeout[th]);
        end

        rden_d  = '0;
        wren_d  = '0;
        out_d   = out_q;
        rdata_d = rdata_q;
        ready_d = access_ready;
        if (access_ready && rd_hit) begin
            rden_d[rd_idx] = 1'b1;
            rdata_d        = io_in[slice_lsb(rd_idx, WORD_WIDTH) +: WORD_WIDTH];
        end
        if (access_ready && wr_hit) begin
            wren_d[wr_idx] = 1'b1;
            out_d[slice_lsb(wr_idx, WORD_WIDTH) +: WORD_WIDTH] = write_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            thread_q  <= '0;
            timeout_q <= '0;
            rden_q    <= '0;
            wren_q    <= '0;
            out_q     <= '0;
            rdata_q   <= '0;
            ready_q   <= 1'b0;
            for (int unsigned th = 0; th < THREAD_COUNT; th++) begin
                retry_q[th] <= '0;
            end
        end else begin
            thread_q  <= thread_d;
            timeout_q <= timeout_d;
            rden_q    <= rden_d;
            wren_q    <= wren_d;
            out_q     <= out_d;
            rdata_q   <= rdata_d;
            ready_q   <= ready_d;
            for (int unsigned th = 0; th < THREAD_COUNT; th++) begin
                retry_q[th] <= retry_d[th];
            end
        end
    end

    assign io_rden    = rden_q;
    assign io_wren    = wren_q;
    assign io_out     = out_q;
    assign read_data  = rdata_q;
    assign IO_ready   = ready_q;
    assign thread_id  = thread_q;
    assign io_timeout = timeout_q;

endmodule

// File: tb/tb_io_port_bank.sv
// Self-checking bench for io_port_bank: directed scenarios plus randomized
// traffic compared against a cycle-level behavioural model.
module tb_io_port_bank;

    localparam int W   = 36;
    localparam int AW  = 10;
    localparam int RPC = 2;
    localparam int RB  = 0;
    localparam int WPC = 2;
    localparam int WB  = 0;
    localparam int TC  = 8;
    localparam int TAW = 3;
    localparam int LIM = 3;
    localparam int RMAX = 255;

    logic              clock = 1'b0;
    logic              reset;
    logic              read_en;
    logic [AW-1:0]     read_addr;
    logic              write_en;
    logic [AW-1:0]     write_addr;
    logic [W-1:0]      write_data;
    logic [RPC-1:0]    io_in_EF;
    logic [W*RPC-1:0]  io_in;
    logic [WPC-1:0]    io_out_EF;
    logic [TC-1:0]     clear_timeout;
    logic [RPC-1:0]    io_rden;
    logic [WPC-1:0]    io_wren;
    logic [W*WPC-1:0]  io_out;
    logic [W-1:0]      read_data;
    logic              IO_ready;
    logic [TAW-1:0]    thread_id;
    logic [TC-1:0]     io_timeout;

    int checks = 0;
    int failures = 0;

    // Behavioural model state: expected outputs after the next edge
    int            m_thread;
    int            m_retry [TC];
    logic [TC-1:0] m_tmo;
    logic [RPC-1:0]   e_rden;
    logic [WPC-1:0]   e_wren;
    logic [W*WPC-1:0] e_out;
    logic [W-1:0]     e_rdata;
    logic             e_ready;

    io_port_bank #(
        .WORD_WIDTH        (W),
        .ADDR_WIDTH        (AW),
        .READ_PORT_COUNT   (RPC),
        .READ_BASE_ADDR    (RB),
        .WRITE_PORT_COUNT  (WPC),
        .WRITE_BASE_ADDR   (WB),
        .THREAD_COUNT      (TC),
        .THREAD_ADDR_WIDTH (TAW),
        .RETRY_WIDTH       (8),
        .RETRY_LIMIT       (LIM)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .read_en       (read_en),
        .read_addr     (read_addr),
        .write_en      (write_en),
        .write_addr    (write_addr),
        .write_data    (write_data),
        .io_in_EF      (io_in_EF),
        .io_in         (io_in),
        .io_out_EF     (io_out_EF),
        .clear_timeout (clear_timeout),
        .io_rden       (io_rden),
        .io_wren       (io_wren),
        .io_out        (io_out),
        .read_data     (read_data),
        .IO_ready      (IO_ready),
        .thread_id     (thread_id),
        .io_timeout    (io_timeout)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic idle();
        read_en       = 1'b0;
        read_addr     = '0;
        write_en      = 1'b0;
        write_addr    = '0;
        write_data    = '0;
        io_in_EF      = '0;
        io_in         = '0;
        io_out_EF     = '0;
        clear_timeout = '0;
    endtask

    // Apply the rules to the current inputs, then advance one clock.
    task automatic tick();
        int  ra, wa, rp, wp;
        bit  rhit, whit, ok;
        ra = int'(read_addr);
        wa = int'(write_addr);
        rhit = read_en && ra >= RB && ra < RB + RPC;
        whit = write_en && wa >= WB && wa < WB + WPC;
        rp = ra - RB;
        wp = wa - WB;
        if (reset) begin
            m_thread = 0;
            for (int t = 0; t < TC; t++) m_retry[t] = 0;
            m_tmo   = '0;
            e_rden  = '0;
            e_wren  = '0;
            e_out   = '0;
            e_rdata = '0;
            e_ready = 1'b0;
        end else begin
            ok = (!rhit || io_in_EF[rp]) && (!whit || io_out_EF[wp]);
            for (int t = 0; t < TC; t++)
                m_tmo[t] = (m_retry[t] >= LIM) || (m_tmo[t] && !clear_timeout[t]);
            if (ok) m_retry[m_thread] = 0;
            else if (m_retry[m_thread] < RMAX) m_retry[m_thread] = m_retry[m_thread] + 1;
            e_rden = '0;
            e_wren = '0;
            if (ok && rhit) begin
                e_rden[rp] = 1'b1;
                e_rdata = io_in[rp*W +: W];
            end
            if (ok && whit) begin
                e_wren[wp] = 1'b1;
                e_out[wp*W +: W] = write_data;
            end
            e_ready  = ok;
            m_thread = (m_thread + 1) % TC;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if (io_rden !== '0 || io_wren !== '0 || io_out !== '0 || read_data !== '0 ||
            IO_ready !== 1'b0 || io_timeout !== '0 || thread_id !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got rden=%b wren=%b out=%h rdata=%h rdy=%b tmo=%b tid=%0d, expected all 0",
                     io_rden, io_wren, io_out, read_data, IO_ready, io_timeout, thread_id);
        end
        reset = 1'b0;
        checks++;
        if (thread_id !== 3'd0) begin
            failures++;
            $display("FAIL reset_release_tid: got %0d expected 0", thread_id);
        end
        tick();
        checks++;
        if (thread_id !== 3'd1) begin
            failures++;
            $display("FAIL thread_increment: got %0d expected 1", thread_id);
        end
    endtask

    task automatic test_thread_wrap();
        idle();
        for (int i = 0; i < TC; i++) tick();
        checks++;
        if (thread_id !== 3'd1) begin
            failures++;
            $display("FAIL thread_wrap: got %0d expected 1", thread_id);
        end
    endtask

    task automatic test_read_hit();
        idle();
        read_en   = 1'b1;
        read_addr = AW'(RB + 1);
        io_in_EF  = 2'b10;
        io_in     = {36'h5, 36'h0};
        tick();
        checks++;
        if (io_rden !== 2'b10 || read_data !== 36'h5 || IO_ready !== 1'b1 || io_wren !== 2'b00) begin
            failures++;
            $display("FAIL read_hit: got rden=%b rdata=%h rdy=%b wren=%b expected 10/5/1/00",
                     io_rden, read_data, IO_ready, io_wren);
        end
        idle();
        tick();
        checks++;
        if (io_rden !== 2'b00 || read_data !== 36'h5 || IO_ready !== 1'b1) begin
            failures++;
            $display("FAIL read_hold: got rden=%b rdata=%h rdy=%b expected 00/5/1", io_rden, read_data, IO_ready);
        end
    endtask

    task automatic test_write_hit();
        logic [W-1:0] d;
        d = W'({$urandom(), $urandom()});
        idle();
        write_en   = 1'b1;
        write_addr = AW'(WB + 1);
        write_data = d;
        io_out_EF  = 2'b11;
        tick();
        checks++;
        if (io_wren !== 2'b10 || io_out[W +: W] !== d || io_out[0 +: W] !== 36'h0 || IO_ready !== 1'b1) begin
            failures++;
            $display("FAIL write_hit: got wren=%b out=%h rdy=%b expected 10 out_hi=%h out_lo=0 rdy=1",
                     io_wren, io_out, IO_ready, d);
        end
        idle();
        tick();
        checks++;
        if (io_wren !== 2'b00 || io_out[W +: W] !== d) begin
            failures++;
            $display("FAIL write_hold: got wren=%b out_hi=%h expected 00/%h", io_wren, io_out[W +: W], d);
        end
    endtask

    task automatic test_write_full();
        idle();
        write_en   = 1'b1;
        write_addr = AW'(WB);
        write_data = 36'hABC;
        io_out_EF  = 2'b00;
        tick();
        checks++;
        if (io_wren !== 2'b00 || IO_ready !== 1'b0) begin
            failures++;
            $display("FAIL write_full: got wren=%b rdy=%b expected 00/0", io_wren, IO_ready);
        end
    endtask

    task automatic test_atomic();
        idle();
        read_en    = 1'b1;
        read_addr  = AW'(RB);
        io_in_EF   = 2'b11;
        io_in      = {36'h7, 36'h9};
        write_en   = 1'b1;
        write_addr = AW'(WB + 1);
        write_data = 36'h123;
        io_out_EF  = 2'b01;
        tick();
        checks++;
        if (io_rden !== 2'b00 || io_wren !== 2'b00 || IO_ready !== 1'b0 || read_data !== e_rdata) begin
            failures++;
            $display("FAIL atomic: got rden=%b wren=%b rdy=%b rdata=%h expected 00/00/0 rdata=%h",
                     io_rden, io_wren, IO_ready, read_data, e_rdata);
        end
    endtask

    task automatic test_miss();
        idle();
        read_en   = 1'b1;
        read_addr = AW'(RB + 5);
        io_in_EF  = 2'b00;
        tick();
        checks++;
        if (IO_ready !== 1'b1 || io_rden !== 2'b00) begin
            failures++;
            $display("FAIL miss: got rdy=%b rden=%b expected 1/00", IO_ready, io_rden);
        end
    endtask

    // One pass of thread 2's slot followed by the other seven threads idle.
    task automatic thread2_slot(input bit blocked);
        read_en   = 1'b0;
        write_en  = 1'b1;
        write_addr = AW'(WB);
        write_data = 36'h2;
        io_out_EF = blocked ? 2'b00 : 2'b11;
        tick();
        write_en  = 1'b0;
        io_out_EF = '0;
        for (int i = 0; i < TC - 1; i++) tick();
    endtask

    task automatic test_timeout();
        idle();
        for (int i = 0; i < TC && m_thread != 2; i++) tick();
        checks++;
        if (thread_id !== 3'd2) begin
            failures++;
            $display("FAIL timeout_align: got tid=%0d expected 2", thread_id);
        end
        thread2_slot(1'b1);
        thread2_slot(1'b1);
        checks++;
        if (io_timeout[2] !== 1'b0) begin
            failures++;
            $display("FAIL timeout_early: got %b expected 0 after two retries", io_timeout[2]);
        end
        thread2_slot(1'b1);
        checks++;
        if (io_timeout[2] !== 1'b1 || io_timeout !== m_tmo) begin
            failures++;
            $display("FAIL timeout_set: got tmo=%b expected %b with bit2=1", io_timeout, m_tmo);
        end
        clear_timeout = 8'b0000_0100;
        thread2_slot(1'b1);
        checks++;
        if (io_timeout[2] !== 1'b1) begin
            failures++;
            $display("FAIL timeout_set_wins: got %b expected 1", io_timeout[2]);
        end
        thread2_slot(1'b0);
        checks++;
        if (io_timeout[2] !== 1'b0) begin
            failures++;
            $display("FAIL timeout_clear: got %b expected 0", io_timeout[2]);
        end
        clear_timeout = '0;
    endtask

    task automatic test_reset_mid();
        idle();
        read_en    = 1'b1;
        read_addr  = AW'(RB);
        io_in_EF   = 2'b01;
        io_in      = {36'h0, 36'h3C};
        write_en   = 1'b1;
        write_addr = AW'(WB);
        write_data = 36'h77;
        io_out_EF  = 2'b01;
        tick();
        checks++;
        if (io_rden !== 2'b01 || io_wren !== 2'b01 || IO_ready !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_access: got rden=%b wren=%b rdy=%b expected 01/01/1", io_rden, io_wren, IO_ready);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (io_rden !== '0 || io_wren !== '0 || io_out !== '0 || read_data !== '0 ||
            IO_ready !== 1'b0 || io_timeout !== '0 || thread_id !== '0) begin
            failures++;
            $display("FAIL reset_mid: got rden=%b wren=%b out=%h rdata=%h rdy=%b tmo=%b tid=%0d expected all 0",
                     io_rden, io_wren, io_out, read_data, IO_ready, io_timeout, thread_id);
        end
        reset = 1'b0;
        idle();
        tick();
        checks++;
        if (thread_id !== 3'd1 || io_rden !== 2'b00) begin
            failures++;
            $display("FAIL reset_mid_release: got tid=%0d rden=%b expected 1/00", thread_id, io_rden);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            reset         = ($urandom_range(0, 63) == 0);
            read_en       = 1'($urandom_range(0, 1));
            read_addr     = AW'($urandom_range(0, 3));
            write_en      = 1'($urandom_range(0, 1));
            write_addr    = AW'($urandom_range(0, 3));
            write_data    = W'({$urandom(), $urandom()});
            io_in_EF      = RPC'($urandom());
            io_in         = (W*RPC)'({$urandom(), $urandom(), $urandom()});
            io_out_EF     = WPC'($urandom());
            clear_timeout = ($urandom_range(0, 7) == 0) ? TC'($urandom()) : '0;
            tick();
            checks++;
            if (io_rden !== e_rden) begin
                failures++;
                $display("FAIL rnd_rden[%0d]: got %b expected %b", n, io_rden, e_rden);
            end
            checks++;
            if (io_wren !== e_wren) begin
                failures++;
                $display("FAIL rnd_wren[%0d]: got %b expected %b", n, io_wren, e_wren);
            end
            checks++;
            if (io_out !== e_out) begin
                failures++;
                $display("FAIL rnd_out[%0d]: got %h expected %h", n, io_out, e_out);
            end
            checks++;
            if (read_data !== e_rdata) begin
                failures++;
                $display("FAIL rnd_rdata[%0d]: got %h expected %h", n, read_data, e_rdata);
            end
            checks++;
            if (IO_ready !== e_ready) begin
                failures++;
                $display("FAIL rnd_ready[%0d]: got %b expected %b", n, IO_ready, e_ready);
            end
            checks++;
            if (int'(thread_id) != m_thread) begin
                failures++;
                $display("FAIL rnd_tid[%0d]: got %0d expected %0d", n, thread_id, m_thread);
            end
            checks++;
            if (io_timeout !== m_tmo) begin
                failures++;
                $display("FAIL rnd_timeout[%0d]: got %b expected %b", n, io_timeout, m_tmo);
            end
        end
        reset = 1'b0;
        idle();
    endtask

    initial begin
        idle();
        reset = 1'b1;
        test_reset();
        test_thread_wrap();
        test_read_hit();
        test_write_hit();
        test_write_full();
        test_atomic();
        test_miss();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/io_port_bank.md
IO_PORT_BANK -- requirements
Module: io_port_bank

Interface
REQ-001 Parameters SHALL be, as name, default, meaning:
- WORD_WIDTH, 36: data word width.
- ADDR_WIDTH, 10: operand address width.
- READ_PORT_COUNT, 2: read ports, at least 1.
- READ_BASE_ADDR, 0: first read-port address.
- WRITE_PORT_COUNT, 2: write ports, at least 1.
- WRITE_BASE_ADDR, 0: first write-port address.
- THREAD_COUNT, 8: hardware threads.
- THREAD_ADDR_WIDTH, 3: thread index width.
- RETRY_WIDTH, 8: width of each retry counter.
- RETRY_LIMIT, 255: retry count that raises a timeout.

REQ-002 Ports SHALL be, as name, direction, width, meaning:
- clock, in, 1: the single clock; all logic is rising-edge.
- reset, in, 1: synchronous, active-high reset.
- read_en, in, 1: the instruction reads an operand this cycle.
- read_addr, in, ADDR_WIDTH: read operand address.
- write_en, in, 1: the instruction writes a result this cycle.
- write_addr, in, ADDR_WIDTH: write operand address.
- write_data, in, WORD_WIDTH: data to write.
- io_in_EF, in, READ_PORT_COUNT: per read port, 1 = not empty.
- io_in, in, WORD_WIDTH*READ_PORT_COUNT: show-ahead read data, flat vector.
- io_out_EF, in, WRITE_PORT_COUNT: per write port, 1 = not full.
- clear_timeout, in, THREAD_COUNT: per-thread timeout clear.
- io_rden, out, READ_PORT_COUNT: one-cycle read pop strobes.
- io_wren, out, WRITE_PORT_COUNT: one-cycle write strobes.
- io_out, out, WORD_WIDTH*WRITE_PORT_COUNT: write data, flat vector.
- read_data, out, WORD_WIDTH: captured read-port word.
- IO_ready, out, 1: the access issued last cycle completed.
- thread_id, out, THREAD_ADDR_WIDTH: thread owning the current cycle.
- io_timeout, out, THREAD_COUNT: sticky per-thread timeout flags.

Function
REQ-003 The internal thread counter SHALL increment every cycle and wrap from THREAD_COUNT-1 to 0; thread_id SHALL show the counter value.
REQ-004 A read SHALL hit a port when read_en=1 and read_addr lies in [READ_BASE_ADDR, READ_BASE_ADDR+READ_PORT_COUNT-1]; port index = read_addr - READ_BASE_ADDR. Write decode SHALL work the same way with the write parameters.
REQ-005 A miss (address outside the port range, or enable low) SHALL count as ready and SHALL generate no strobe.
REQ-006 Cycle t access_ready SHALL be (read miss or io_in_EF[rport]) AND (write miss or io_out_EF[wport]).
REQ-007 Access SHALL be atomic: when access_ready=0, neither io_rden nor io_wren is asserted, even if one side alone is ready.
REQ-008 When access_ready=1 at cycle t, cycle t+1 SHALL show:
- exactly one io_rden bit for a read hit;
- exactly one io_wren bit for a write hit, with write_data on that port's io_out slice;
- read_data = io_in[rport] as sampled at t;
- IO_ready=1.
REQ-009 At cycle t+1, IO_ready SHALL equal access_ready of cycle t, and strobes SHALL be deasserted when it is 0.
REQ-010 io_out slices SHALL hold their last written value when not strobed; read_data SHALL hold when there is no read hit.
REQ-011 Each thread SHALL own a RETRY_WIDTH-bit retry counter, updated only in that thread's cycles:
- +1, saturating, when access_ready=0;
- cleared when access_ready=1.
REQ-012 io_timeout[th] SHALL set on the cycle after thread th's counter reaches RETRY_LIMIT, and SHALL stay set until reset or clear_timeout[th]=1.
REQ-013 If set and clear happen in the same cycle, set SHALL win.
REQ-014 A read hit and a write hit on the same numeric port index SHALL be independent; read and write ports are separate spaces.

Reset
REQ-015 While reset=1, on each clock edge:
- thread counter, retry counters, io_timeout, io_rden, io_wren, IO_ready, read_data and io_out SHALL go to 0;
- any access in flight SHALL be dropped with no strobe.
REQ-016 On the first cycle after reset deasserts, thread_id SHALL be 0.

Structure
REQ-017 Shared package io_port_pkg SHALL hold the port-index width function (clog2), the EF polarity constants, and the flat-vector slice helper.
REQ-018 Address decode SHALL live in one sub-module, io_port_decoder, instantiated twice (read, write), producing port index and hit.

Verification
REQ-019 Read hit, ready: read_addr=READ_BASE_ADDR+1, io_in_EF=2'b10, io_in[1]=36'h5 -> at t+1, io_rden=2'b10, read_data=36'h5, IO_ready=1.
REQ-020 Write hit, full: write_addr=WRITE_BASE_ADDR, io_out_EF=2'b00 -> at t+1, io_wren=0, IO_ready=0; the thread's retry count increments by 1.
REQ-021 Atomicity: read hit ready and write hit full in the same cycle -> io_rden=0, io_wren=0, IO_ready=0.
REQ-022 Timeout: RETRY_LIMIT=3, thread 2 blocked 3 times -> io_timeout[2]=1. Then clear_timeout[2]=1 while thread 2's next blocked access sets again -> io_timeout[2] stays 1. An unblocked access followed by a clear -> io_timeout[2]=0.
REQ-023 Reset mid-operation: assert reset on the cycle after a ready access -> no strobe in the next cycle, all outputs 0, thread_id=0 after release.
REQ-024 Miss path: read_addr outside the port range, io_in_EF=0 -> IO_ready=1, io_rden=0, retry count cleared.
